// File: rtl/sfpp_reconfig_st_pkg.sv
// rtl/sfpp_reconfig_st_pkg.sv - shared byte-stream framing constants
package sfpp_reconfig_st_pkg;

   localparam logic [7:0] SOP_CHAR  = 8'h7A;
   localparam logic [7:0] EOP_CHAR  = 8'h7B;
   localparam logic [7:0] CHAN_CHAR = 8'h7C;
   localparam logic [7:0] ESC_CHAR  = 8'h7D;
   localparam logic [7:0] ESC_XOR   = 8'h20;

endpackage

// File: rtl/sfpp_reconfig_bytes_to_packets.sv
// rtl/sfpp_reconfig_bytes_to_packets.sv - escaped byte stream to channelised packet stream decoder
module sfpp_reconfig_bytes_to_packets
   import sfpp_reconfig_st_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic       in_ready,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic [7:0] out_channel,
   output logic       out_startofpacket,
   output logic       out_endofpacket
);

   logic       esc_pending;
   logic       chan_pending;
   logic       sop_pending;
   logic       eop_pending;
   logic [7:0] channel_q;
   logic       accept;
   logic       is_ctrl;
   logic [7:0] value;

   // Held beat only blocks input while it is stalled; reset always drains.
   assign in_ready = reset | ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;
   assign value    = esc_pending ? (in_data ^ ESC_XOR) : in_data;

   always_comb begin
      is_ctrl = 1'b0;
      if (!esc_pending) begin
         case (in_data)
            SOP_CHAR, EOP_CHAR, CHAN_CHAR, ESC_CHAR: is_ctrl = 1'b1;
            default:                                 is_ctrl = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         esc_pending       <= 1'b0;
         chan_pending      <= 1'b0;
         sop_pending       <= 1'b0;
         eop_pending       <= 1'b0;
         channel_q         <= 8'h00;
         out_valid         <= 1'b0;
         out_data          <= 8'h00;
         out_channel       <= 8'h00;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            if (is_ctrl) begin
               case (in_data)
                  SOP_CHAR:  sop_pending  <= 1'b1;
                  EOP_CHAR:  eop_pending  <= 1'b1;
                  CHAN_CHAR: chan_pending <= 1'b1;
                  default:   esc_pending  <= 1'b1;
               endcase
            end else begin
               esc_pending <= 1'b0;
               // A pending channel marker swallows the next value byte.
               if (chan_pending) begin
                  channel_q    <= value;
                  chan_pending <= 1'b0;
               end else begin
                  out_valid         <= 1'b1;
                  out_data          <= value;
                  out_channel       <= channel_q;
                  out_startofpacket <= sop_pending;
                  out_endofpacket   <= eop_pending;
                  sop_pending       <= 1'b0;
                  eop_pending       <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sfpp_reconfig_bytes_to_packets.sv
// tb/tb_sfpp_reconfig_bytes_to_packets.sv - directed vector bench for the byte-to-packet decoder
module tb_sfpp_reconfig_bytes_to_packets;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_ready;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic [7:0] out_channel;
   logic       out_startofpacket;
   logic       out_endofpacket;

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct {
      logic [7:0] din;
      logic       ev;
      logic [7:0] ed;
      logic [7:0] ech;
      logic       es;
      logic       ee;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] got[$];
   logic       mon_en = 1'b0;

   sfpp_reconfig_bytes_to_packets dut (
      .clk               (clk),
      .reset             (reset),
      .in_ready          (in_ready),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_channel       (out_channel),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mon_en && out_valid && out_ready) got.push_back(out_data);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] din, input logic ev, input logic [7:0] ed,
                               input logic [7:0] ech, input logic es, input logic ee);
      vec_t v;
      v.din = din; v.ev = ev; v.ed = ed; v.ech = ech; v.es = es; v.ee = ee;
      return v;
   endfunction

   task automatic feed(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk); #1;
   endtask

   initial begin
      // Framed packet on channel 1
      vecs.push_back(mk(8'h7A, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h7C, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h01, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h41, 1, 8'h41, 8'h01, 1, 0));
      vecs.push_back(mk(8'h42, 1, 8'h42, 8'h01, 0, 0));
      vecs.push_back(mk(8'h7B, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h43, 1, 8'h43, 8'h01, 0, 1));
      // Escaped marker values are payload
      vecs.push_back(mk(8'h7A, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h7D, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h5A, 1, 8'h7A, 8'h01, 1, 0));
      vecs.push_back(mk(8'h7B, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h7D, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h5D, 1, 8'h7D, 8'h01, 0, 1));
      // Escaped channel value, single-byte packet
      vecs.push_back(mk(8'h7C, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h7D, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h5C, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h7A, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h7B, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h55, 1, 8'h55, 8'h7C, 1, 1));
      // Marker between channel marker and channel value; escaped ordinary byte
      vecs.push_back(mk(8'h7C, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h7A, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h22, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h11, 1, 8'h11, 8'h22, 1, 0));
      vecs.push_back(mk(8'h7D, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(8'h61, 1, 8'h41, 8'h22, 0, 0));

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'h00);
      chk("rst_out_channel", 32'(out_channel), 32'h00);
      chk("rst_sop_eop", 32'({out_startofpacket, out_endofpacket}), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         feed(vecs[i].din);
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d_beat", i),
                32'({out_data, out_channel, out_startofpacket, out_endofpacket}),
                32'({vecs[i].ed, vecs[i].ech, vecs[i].es, vecs[i].ee}));
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;

      // Continuous data with a three-cycle downstream stall
      begin
         int  idx;
         logic acc;
         idx = 0;
         got.delete();
         mon_en = 1'b1;
         for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (idx < 8);
            in_data   = 8'h10 + 8'(idx);
            #1;
            if (c >= 3 && c <= 5) begin
               chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
               chk($sformatf("bp_hold_c%0d", c),
                   32'({out_valid, out_data, out_channel, out_startofpacket, out_endofpacket}),
                   32'({1'b1, 8'h12, 8'h22, 1'b0, 1'b0}));
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
         end
         mon_en = 1'b0;
         in_valid = 1'b0;
         chk("bp_count", 32'(got.size()), 32'd8);
         for (int i = 0; i < 8 && i < got.size(); i++) begin
            chk($sformatf("bp_beat%0d", i), 32'(got[i]), 32'(8'h10 + 8'(i)));
         end
      end

      // Reset while a beat is held: input stays open, beat is discarded
      out_ready = 1'b1;
      feed(8'h44);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      reset     = 1'b1;
      #1;
      chk("rst_hold_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_hold_drop_valid", 32'(out_valid), 32'd0);
      chk("rst_hold_drop_data", 32'(out_data), 32'h00);

      // Reset after SOP and channel marker, before the channel value
      out_ready = 1'b1;
      feed(8'h7A);
      feed(8'h7C);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      feed(8'h33);
      in_valid = 1'b0;
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_beat",
          32'({out_data, out_channel, out_startofpacket, out_endofpacket}),
          32'({8'h33, 8'h00, 1'b0, 1'b0}));

      @(posedge clk); #1;
      chk("post_rst_drained", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
